// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - 5-digit multiplexed common-anode 7-segment scanner
module seg7_scanner #(
  parameter int DIV      = 50000,
  parameter int GUARD    = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d5,
  input  logic [3:0] d4,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [4:0] dp_en,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_C  = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam bit            LZ_ON   = (BLANK_LZ != 0);

  logic [CW-1:0]     cnt;
  logic [2:0]        idx;
  logic [4:0][3:0]   snap;
  logic [4:0]        snap_dp;

  logic              tick;
  logic [4:0]        lz;
  logic              zero_run;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;
  logic [6:0]        seg_dec;
  logic              active;
  logic [4:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  assign tick = (cnt == LAST_C);

  always_comb begin
    // lz[k]: digit k and every digit above it are zero or blank
    lz       = '0;
    zero_run = LZ_ON;
    for (int k = 4; k >= 1; k--) begin
      zero_run = zero_run && ((snap[k] == 4'd0) || (snap[k] == 4'hF));
      lz[k]    = zero_run;
    end

    cur_digit = snap[0];
    cur_dp    = snap_dp[0];
    cur_blank = 1'b0;
    case (idx)
      3'd1:    begin cur_digit = snap[1]; cur_dp = snap_dp[1]; cur_blank = lz[1]; end
      3'd2:    begin cur_digit = snap[2]; cur_dp = snap_dp[2]; cur_blank = lz[2]; end
      3'd3:    begin cur_digit = snap[3]; cur_dp = snap_dp[3]; cur_blank = lz[3]; end
      3'd4:    begin cur_digit = snap[4]; cur_dp = snap_dp[4]; cur_blank = lz[4]; end
      default: begin cur_digit = snap[0]; cur_dp = snap_dp[0]; cur_blank = 1'b0;  end
    endcase

    case (cur_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      4'hF:    seg_dec = 7'b1111111;
      default: seg_dec = 7'b0111111;
    endcase

    active  = (cnt >= GUARD_C);
    seg_nxt = cur_blank ? 7'b1111111 : seg_dec;
    an_nxt  = active ? ~(5'b00001 << idx) : 5'b11111;
    dp_nxt  = active ? ~cur_dp : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= 3'd0;
      snap        <= '1;
      snap_dp     <= '0;
      an          <= 5'b11111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (idx == 3'd4);
      if (tick) begin
        cnt <= '0;
        if (idx == 3'd4) begin
          idx     <= 3'd0;
          snap    <= {d5, d4, d3, d2, d1};
          snap_dp <= dp_en;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - scoreboard bench for seg7_scanner (DIV=4, GUARD=1)
module tb_seg7_scanner;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] DSH = 7'b0111111;
  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    logic [4:0][3:0] dig;
    logic [4:0]      dpe;
    logic [4:0][6:0] elz;
    logic [4:0][6:0] enl;
    bit              mid;
  } tvec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] d5, d4, d3, d2, d1;
  logic [4:0] dp_en;
  logic [4:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;

  int vectors = 0;
  int fails   = 0;
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  tvec_t tv[8];

  seg7_scanner #(.DIV(4), .GUARD(1), .BLANK_LZ(1)) u_lz (
    .clk(clk), .rst_n(rst_n), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1),
    .dp_en(dp_en), .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  seg7_scanner #(.DIV(4), .GUARD(1), .BLANK_LZ(0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1),
    .dp_en(dp_en), .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n && an0 != 5'b11111 && q0.size() != 0) begin
      e = q0.pop_front();
      vectors++;
      if ({an0, seg0, dp0} !== e) begin
        fails++;
        $display("FAIL slot_lz: an/seg/dp got %b/%b/%b want %b/%b/%b",
                 an0, seg0, dp0, e[12:8], e[7:1], e[0]);
      end
    end
    if (rst_n && an1 != 5'b11111 && q1.size() != 0) begin
      e = q1.pop_front();
      vectors++;
      if ({an1, seg1, dp1} !== e) begin
        fails++;
        $display("FAIL slot_nolz: an/seg/dp got %b/%b/%b want %b/%b/%b",
                 an1, seg1, dp1, e[12:8], e[7:1], e[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_an_lz", 32'(an0), 32'h1f);
    chk("rst_seg_lz", 32'(seg0), 32'h7f);
    chk("rst_dp_lz", 32'(dp0), 32'h1);
    chk("rst_fs_lz", 32'(fs0), 32'h0);
    chk("rst_an_nolz", 32'(an1), 32'h1f);
    chk("rst_seg_nolz", 32'(seg1), 32'h7f);
  endtask

  task automatic push_frame(input logic [4:0][6:0] elz, input logic [4:0][6:0] enl,
                            input logic [4:0] dpe);
    logic [4:0] a;
    for (int s = 0; s < 5; s++) begin
      a = ~(5'b00001 << s);
      for (int r = 0; r < 3; r++) begin
        q0.push_back({a, elz[s], ~dpe[s]});
        q1.push_back({a, enl[s], ~dpe[s]});
      end
    end
  endtask

  task automatic wait_fs(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!fs0 && cyc < limit);
    if (!fs0) begin
      vectors++;
      fails++;
      $display("FAIL frame_start_timeout: got none within %0d cycles", limit);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d left want 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    #1;
  endtask

  task automatic release_and_check_first_frame();
    int c;
    rst_n = 1'b1;
    push_frame({5{BLK}}, {5{BLK}}, 5'b00000);
    wait_fs(100, c);
    chk("fs_cycle", 32'(c), 32'd20);
    chk("fs_lockstep", 32'(fs1), 32'h1);
    @(posedge clk); #1;
    chk("fs_width", 32'(fs0), 32'h0);
  endtask

  initial begin
    int c;
    tv[0] = '{dig: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, dpe: 5'b00000,
              elz: {S1, S2, S3, S4, S5}, enl: {S1, S2, S3, S4, S5}, mid: 1'b0};
    tv[1] = '{dig: {4'd0, 4'd0, 4'd0, 4'd4, 4'd2}, dpe: 5'b00000,
              elz: {BLK, BLK, BLK, S4, S2}, enl: {S0, S0, S0, S4, S2}, mid: 1'b0};
    tv[2] = '{dig: {4'hF, 4'hF, 4'hF, 4'hF, 4'hA}, dpe: 5'b00000,
              elz: {BLK, BLK, BLK, BLK, DSH}, enl: {BLK, BLK, BLK, BLK, DSH}, mid: 1'b0};
    tv[3] = '{dig: {4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, dpe: 5'b00000,
              elz: {5{BLK}}, enl: {5{BLK}}, mid: 1'b0};
    tv[4] = '{dig: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, dpe: 5'b00000,
              elz: {BLK, BLK, BLK, BLK, S0}, enl: {5{S0}}, mid: 1'b0};
    tv[5] = '{dig: {4'hF, 4'd0, 4'hC, 4'd0, 4'd9}, dpe: 5'b10001,
              elz: {BLK, BLK, DSH, S0, S9}, enl: {BLK, S0, DSH, S0, S9}, mid: 1'b0};
    tv[6] = '{dig: {4'd0, 4'd0, 4'd0, 4'd0, 4'd3}, dpe: 5'b00100,
              elz: {BLK, BLK, BLK, BLK, S3}, enl: {S0, S0, S0, S0, S3}, mid: 1'b1};
    tv[7] = '{dig: {4'd0, 4'd0, 4'd0, 4'd0, 4'd7}, dpe: 5'b00100,
              elz: {BLK, BLK, BLK, BLK, S7}, enl: {S0, S0, S0, S0, S7}, mid: 1'b0};

    rst_n = 1'b0;
    {d5, d4, d3, d2, d1} = {5{4'hF}};
    dp_en = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    release_and_check_first_frame();

    for (int i = 0; i < 8; i++) begin
      drain();
      if (i != 7) {d5, d4, d3, d2, d1} = tv[i].dig;
      dp_en = tv[i].dpe;
      wait_fs(100, c);
      @(posedge clk); #1;
      push_frame(tv[i].elz, tv[i].enl, tv[i].dpe);
      if (tv[i].mid) begin
        repeat (8) @(posedge clk);
        #1;
        d1 = 4'd7;
      end
    end

    drain();
    wait_fs(100, c);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_an", 32'(an0), 32'h1b);
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    release_and_check_first_frame();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD stage. It consumes the five BCD digit nibbles D5..D1, including the 4'b1111 blank code. Each frame it snapshots them, then time-multiplexes them onto a 5-digit common-anode display using active-low segments and anodes. It adds leading-zero blanking, an error dash for illegal codes, and a ghosting guard interval between digit slots.

## Interface
- DIV, 50000: prescaler; clock cycles per digit slot; legal range 2..2^20.
- GUARD, 2: cycles at the start of each slot with all anodes off; must satisfy GUARD < DIV.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 disables it.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- D5..D1  in  4 each  BCD digits; D1 is least significant; 4'b1111 means blank.
- dp_en  in  5  decimal-point enables; bit k belongs to digit D(k+1).
- an  out  5  anode enables, active-low; bit k drives digit D(k+1).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- Internal state:
  - cnt: slot counter, 0..DIV-1.
  - idx: digit index, 0..4 (0 = D1).
  - snap: 5×4-bit copy of D5..D1.
  - snap_dp: 5-bit copy of dp_en.
- Slot tick: asserted when cnt == DIV-1. On a tick, cnt returns to 0 and idx advances (4 wraps to 0). Otherwise cnt increments.
- Snapshot: on the tick where idx == 4, snap and snap_dp load the current inputs. The same edge sets frame_start = 1 for exactly one cycle. Inputs are ignored at all other times, so there is no tearing within a frame.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k (k = 4 down to 1) is blanked if snap[k] and every higher snap digit are 0 or 4'b1111.
  - D1 is never blanked.
  - A blanked digit drives seg = 7'b1111111, but its dp still follows snap_dp.
- Decode of the current digit:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
  - 10..14 → dash, 0111111
  - 15 → blank, 1111111
- Anodes: an = ~(5'b00001 << idx) when cnt ≥ GUARD; otherwise an = 5'b11111 (guard interval).
- dp = ~snap_dp[idx] during the active part of the slot; dp = 1 during the guard interval.

## Timing
- an, seg, dp and frame_start are registered. They reflect the cnt/idx/snap state of the previous cycle (one-cycle output lag).
- Frame length: 5·DIV cycles. Each digit is lit for DIV-GUARD cycles per frame.
- Input-to-display latency:
  - The snapshot samples inputs on the clock edge of the idx==4 tick.
  - The new D1 value appears on the pins at most 5·DIV + GUARD + 1 cycles after an input change.
- Reset values (asserted asynchronously, immediately, including mid-frame):
  - cnt = 0, idx = 0, snap = all 4'b1111, snap_dp = 0
  - an = 5'b11111, seg = 7'b1111111, dp = 1, frame_start = 0
- After rst_n deasserts:
  - The first frame shows blanks, since snap is all 4'b1111.
  - The first snapshot and frame_start occur at cycle 5·DIV after release.
- A reset asserted during a slot discards the partial slot and the current snap contents. There is no glitch pulse on an.
- An input change in the same cycle as the snapshot edge: the value sampled at that edge wins. Later changes wait for the next frame.

## Test plan
- Reset/idle (DIV=4, GUARD=1): hold rst_n=0 → an=11111, seg=1111111, dp=1. Release → first frame all blank; frame_start pulses at cycle 20.
- Scan order (DIV=4, GUARD=1, inputs 1,2,3,4,5 for D5..D1, BLANK_LZ=1):
  - After the snapshot, an walks 11110→11101→11011→10111→01111.
  - seg = 0010010, 0011001, 0110000, 0100100, 1111001.
  - Each digit is active 3 cycles, preceded by 1 cycle of an=11111.
- Leading zeros: D5..D1 = 0,0,0,4,2 → D5–D3 slots seg=1111111. With BLANK_LZ=0 the same inputs show 1000000 in those slots.
- Codes: D1=4'hA → dash 0111111; D1=4'hF → blank. D1=0 with all digits 0 → D1 shows 1000000 and D2–D5 are blank.
- Snapshot isolation: change D1 from 3 to 7 mid-frame → display holds 3 until the next frame_start, then shows 1111000. dp_en=00100 lights dp only in the D3 slot.
- Async reset mid-frame: drop rst_n while idx=2 and cnt=2 → outputs return to reset values in the same cycle. After release, scanning restarts at idx 0 with a blank first frame.
